// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions used by both the write and read pointer
// handlers: the default address width, depth derivation, Gray/binary
// conversion helpers and the "full" comparison that inverts the two MSBs of
// the far-side Gray pointer.
package fifo_pkg;

  localparam int unsigned ADDRSIZE_DEF = 6;

  // Helpers work on a wide word so any pointer width up to 32 bits can be
  // zero-extended in and truncated back out by the caller.
  localparam int unsigned FN_W = 32;
  typedef logic [FN_W-1:0] word_t;

  // Registered write-side flags kept together so reset and update stay tidy.
  typedef struct packed {
    logic full;
    logic almost_full;
    logic overflow;
  } wr_flags_t;

  function automatic int unsigned depth_of(input int unsigned addrsize);
    return 32'd1 << addrsize;
  endfunction

  function automatic word_t bin2gray(input word_t bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic word_t gray2bin(input word_t gray);
    word_t bin;
    bin[FN_W-1] = gray[FN_W-1];
    for (int i = FN_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

  // Full when our next Gray pointer equals the synchronised read pointer
  // with its two MSBs inverted (one full lap ahead). ptr_w is the real
  // pointer width, ADDRSIZE+1.
  function automatic logic full_match(input word_t gray_next,
                                      input word_t rptr_gray,
                                      input int unsigned ptr_w);
    return gray_next == (rptr_gray ^ (word_t'(3) << (ptr_w - 2)));
  endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Combinational Gray-to-binary converter (XOR prefix from the MSB down).
// Ports:
//   gray_i  W-bit Gray code input
//   bin_o   W-bit binary equivalent
module gray2bin_conv #(
  parameter int unsigned W = 7
) (
  input  logic [W-1:0] gray_i,
  output logic [W-1:0] bin_o
);

  // Each binary bit is the parity of all Gray bits at or above it.
  for (genvar i = 0; i < W; i++) begin : g_bit
    assign bin_o[i] = ^gray_i[W-1:i];
  end

endmodule

// File: rtl/write_handler.sv
// Write-domain pointer and flag logic of the async FIFO, clocked by wr_clk.
// Advances the binary/Gray write pointers on accepted writes, publishes the
// Gray pointer to the read-domain synchroniser and derives full, almost-full,
// fill level and a sticky overflow flag from the synchronised read pointer.
// Ports:
//   wr_clk, wr_rst    clock, asynchronous active-low reset
//   wr_en             producer write request
//   wq2_rptr          Gray read pointer, already synchronised into wr_clk
//   wr_ovf_clr        clears the sticky overflow flag
//   wr_accept         write accepted this cycle (memory write enable)
//   wr_addr           binary write pointer (memory uses the low ADDRSIZE bits)
//   wr_ptr            Gray write pointer for the read domain
//   wr_full           full flag
//   wr_almost_full    free entries <= AF_MARGIN
//   wr_level          fill level 0..DEPTH, pessimistic
//   wr_overflow       sticky: a write was attempted while full
module write_handler
  import fifo_pkg::*;
#(
  parameter int unsigned ADDRSIZE  = ADDRSIZE_DEF,
  parameter int unsigned AF_MARGIN = 4
) (
  input  logic              wr_clk,
  input  logic              wr_rst,
  input  logic              wr_en,
  input  logic [ADDRSIZE:0] wq2_rptr,
  input  logic              wr_ovf_clr,
  output logic              wr_accept,
  output logic [ADDRSIZE:0] wr_addr,
  output logic [ADDRSIZE:0] wr_ptr,
  output logic              wr_full,
  output logic              wr_almost_full,
  output logic [ADDRSIZE:0] wr_level,
  output logic              wr_overflow
);

  localparam int unsigned PTRW  = ADDRSIZE + 1;
  localparam int unsigned DEPTH = depth_of(ADDRSIZE);
  localparam logic [ADDRSIZE:0] AF_THRESH = PTRW'(DEPTH - AF_MARGIN);

  logic [ADDRSIZE:0] wr_addr_q, wr_addr_d;
  logic [ADDRSIZE:0] wr_ptr_q, wr_ptr_d;
  logic [ADDRSIZE:0] wr_level_q, wr_level_d;
  wr_flags_t         flags_q, flags_d;
  logic [ADDRSIZE:0] rbin;

  gray2bin_conv #(.W(PTRW)) u_rptr_conv (
    .gray_i (wq2_rptr),
    .bin_o  (rbin)
  );

  // Only the registered full flag gates acceptance, so a read that frees
  // space this very cycle is not seen until the next one.
  assign wr_accept = wr_en & ~flags_q.full;

  // NOTE: every always_comb output gets a value on every path (here
  // unconditionally) so no latch is inferred.
  always_comb begin
    wr_addr_d  = wr_addr_q + {{ADDRSIZE{1'b0}}, wr_accept};
    wr_ptr_d   = PTRW'(bin2gray(word_t'(wr_addr_d)));
    // Modulo subtraction of the stale read pointer: level can only
    // over-report, never under-report.
    wr_level_d = wr_addr_d - rbin;
    flags_d.full        = full_match(word_t'(wr_ptr_d), word_t'(wq2_rptr), PTRW);
    flags_d.almost_full = (wr_level_d >= AF_THRESH);
    // A fresh overflow beats a simultaneous clear.
    flags_d.overflow    = (wr_en & flags_q.full) | (flags_q.overflow & ~wr_ovf_clr);
  end

  // NOTE: state registers use non-blocking assignments so all flops sample
  // the same pre-edge values.
  always_ff @(posedge wr_clk or negedge wr_rst) begin
    if (!wr_rst) begin
      wr_addr_q  <= '0;
      wr_ptr_q   <= '0;
      wr_level_q <= '0;
      flags_q    <= '0;
    end else begin
      wr_addr_q  <= wr_addr_d;
      wr_ptr_q   <= wr_ptr_d;
      wr_level_q <= wr_level_d;
      flags_q    <= flags_d;
    end
  end

  assign wr_addr        = wr_addr_q;
  assign wr_ptr         = wr_ptr_q;
  assign wr_level       = wr_level_q;
  assign wr_full        = flags_q.full;
  assign wr_almost_full = flags_q.almost_full;
  assign wr_overflow    = flags_q.overflow;

endmodule

// File: tb/tb_write_handler.sv
// Directed self-checking bench for write_handler (ADDRSIZE=6, AF_MARGIN=4).
module tb_write_handler;

  logic       wr_clk = 1'b0;
  logic       wr_rst;
  logic       wr_en;
  logic [6:0] wq2_rptr;
  logic       wr_ovf_clr;
  logic       wr_accept;
  logic [6:0] wr_addr;
  logic [6:0] wr_ptr;
  logic       wr_full;
  logic       wr_almost_full;
  logic [6:0] wr_level;
  logic       wr_overflow;

  int errors = 0;
  int checks = 0;
  logic [6:0] prev_ptr = '0;

  write_handler #(.ADDRSIZE(6), .AF_MARGIN(4)) dut (
    .wr_clk         (wr_clk),
    .wr_rst         (wr_rst),
    .wr_en          (wr_en),
    .wq2_rptr       (wq2_rptr),
    .wr_ovf_clr     (wr_ovf_clr),
    .wr_accept      (wr_accept),
    .wr_addr        (wr_addr),
    .wr_ptr         (wr_ptr),
    .wr_full        (wr_full),
    .wr_almost_full (wr_almost_full),
    .wr_level       (wr_level),
    .wr_overflow    (wr_overflow)
  );

  always #5 wr_clk = ~wr_clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  function automatic logic [6:0] gray(input logic [6:0] b);
    return b ^ (b >> 1);
  endfunction

  // One clock edge, sampled 1 time unit later; Gray pointer must move by at
  // most one bit per edge outside reset.
  task automatic tick();
    @(posedge wr_clk);
    #1;
    if (wr_rst) begin
      checks++;
      if ($countones(wr_ptr ^ prev_ptr) > 1) begin
        errors++;
        $display("FAIL gray_step: wr_ptr %h -> %h changes more than one bit", prev_ptr, wr_ptr);
      end
    end
    prev_ptr = wr_ptr;
  endtask

  task automatic apply_reset();
    wr_rst = 1'b0;
    tick();
    wr_rst = 1'b1;
  endtask

  task automatic test_reset();
    wr_rst = 1'b0; wr_en = 1'b0; wr_ovf_clr = 1'b0; wq2_rptr = '0;
    #3;
    checks++;
    if ({wr_addr, wr_ptr, wr_full, wr_almost_full, wr_level, wr_overflow} !== 24'h0) begin
      errors++;
      $display("FAIL reset_state: got addr=%h ptr=%h full=%b af=%b lvl=%0d ovf=%b, want all zero",
               wr_addr, wr_ptr, wr_full, wr_almost_full, wr_level, wr_overflow);
    end
    tick();
    wr_rst = 1'b1;
  endtask

  task automatic test_fill();
    wr_en = 1'b1;
    #1;
    checks++;
    if (wr_accept !== 1'b1) begin
      errors++; $display("FAIL fill_accept: wr_accept=%b want 1", wr_accept);
    end
    for (int i = 1; i <= 64; i++) begin
      tick();
      checks++;
      if ({wr_addr, wr_full, wr_almost_full, wr_level} !== {7'(i), i == 64, i >= 60, 7'(i)}) begin
        errors++;
        $display("FAIL fill_%0d: addr=%0d full=%b af=%b lvl=%0d, want addr=%0d full=%b af=%b lvl=%0d",
                 i, wr_addr, wr_full, wr_almost_full, wr_level, i, i == 64, i >= 60, i);
      end
    end
    wr_en = 1'b0;
    checks++;
    if (wr_ptr !== 7'h60) begin
      errors++; $display("FAIL fill_gray: wr_ptr=%h want 60", wr_ptr);
    end
  endtask

  task automatic test_overflow();
    wr_en = 1'b1;
    #1;
    checks++;
    if (wr_accept !== 1'b0) begin
      errors++; $display("FAIL ovf_accept: wr_accept=%b want 0 while full", wr_accept);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({wr_addr, wr_overflow} !== {7'd64, 1'b1}) begin
        errors++; $display("FAIL ovf_hold_%0d: addr=%0d ovf=%b want addr=64 ovf=1", i, wr_addr, wr_overflow);
      end
    end
    wr_ovf_clr = 1'b1;
    tick();
    checks++;
    if (wr_overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_set_wins: ovf=%b want 1", wr_overflow);
    end
    wr_en = 1'b0;
    tick();
    checks++;
    if (wr_overflow !== 1'b0) begin
      errors++; $display("FAIL ovf_clear: ovf=%b want 0", wr_overflow);
    end
    wr_ovf_clr = 1'b0;
  endtask

  task automatic test_release();
    wq2_rptr = 7'h01;
    tick();
    checks++;
    if ({wr_addr, wr_full, wr_almost_full, wr_level} !== {7'd64, 1'b0, 1'b1, 7'd63}) begin
      errors++;
      $display("FAIL release: addr=%0d full=%b af=%b lvl=%0d want addr=64 full=0 af=1 lvl=63",
               wr_addr, wr_full, wr_almost_full, wr_level);
    end
    wr_en = 1'b1;
    #1;
    checks++;
    if (wr_accept !== 1'b1) begin
      errors++; $display("FAIL release_accept: wr_accept=%b want 1", wr_accept);
    end
    tick();
    wr_en = 1'b0;
    checks++;
    if ({wr_addr, wr_ptr, wr_full, wr_level} !== {7'd65, 7'h61, 1'b1, 7'd64}) begin
      errors++;
      $display("FAIL refill: addr=%0d ptr=%h full=%b lvl=%0d want addr=65 ptr=61 full=1 lvl=64",
               wr_addr, wr_ptr, wr_full, wr_level);
    end
    // Read pointer frees a slot in the same cycle as a write: rejected now,
    // accepted next cycle.
    wq2_rptr = gray(7'd2);
    wr_en = 1'b1;
    #1;
    checks++;
    if (wr_accept !== 1'b0) begin
      errors++; $display("FAIL same_cycle_reject: wr_accept=%b want 0", wr_accept);
    end
    tick();
    checks++;
    if ({wr_addr, wr_full, wr_accept} !== {7'd65, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL same_cycle_next: addr=%0d full=%b accept=%b want addr=65 full=0 accept=1",
               wr_addr, wr_full, wr_accept);
    end
    tick();
    wr_en = 1'b0;
    checks++;
    if ({wr_addr, wr_ptr, wr_full} !== {7'd66, 7'h63, 1'b1}) begin
      errors++;
      $display("FAIL same_cycle_write: addr=%0d ptr=%h full=%b want addr=66 ptr=63 full=1",
               wr_addr, wr_ptr, wr_full);
    end
  endtask

  task automatic test_wrap();
    wr_en = 1'b0; wr_ovf_clr = 1'b0; wq2_rptr = '0;
    apply_reset();
    // Read pointer trails by 27 so the level never nears full.
    for (int a = 0; a < 127; a++) begin
      wq2_rptr = gray((a >= 27) ? 7'(a - 27) : 7'd0);
      wr_en = 1'b1;
      tick();
    end
    checks++;
    if ({wr_addr, wr_ptr, wr_full} !== {7'd127, 7'h40, 1'b0}) begin
      errors++; $display("FAIL wrap_preload: addr=%0d ptr=%h full=%b want addr=127 ptr=40 full=0",
                         wr_addr, wr_ptr, wr_full);
    end
    wq2_rptr = gray(7'd100);
    tick();
    wr_en = 1'b0;
    checks++;
    if ({wr_addr, wr_ptr, wr_level, wr_full, wr_almost_full} !== {7'd0, 7'd0, 7'd28, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL wrap: addr=%0d ptr=%h lvl=%0d full=%b af=%b want addr=0 ptr=0 lvl=28 full=0 af=0",
               wr_addr, wr_ptr, wr_level, wr_full, wr_almost_full);
    end
  endtask

  task automatic test_reset_mid();
    wq2_rptr = '0;
    apply_reset();
    wr_en = 1'b1;
    for (int i = 0; i < 65; i++) tick();
    wr_en = 1'b0;
    wq2_rptr = gray(7'd24);
    tick();
    checks++;
    if ({wr_level, wr_overflow, wr_full} !== {7'd40, 1'b1, 1'b0}) begin
      errors++; $display("FAIL pre_reset: lvl=%0d ovf=%b full=%b want lvl=40 ovf=1 full=0",
                         wr_level, wr_overflow, wr_full);
    end
    #2;
    wr_rst = 1'b0;
    #1;
    checks++;
    if ({wr_addr, wr_ptr, wr_full, wr_almost_full, wr_level, wr_overflow} !== 24'h0) begin
      errors++;
      $display("FAIL async_reset: addr=%h ptr=%h full=%b af=%b lvl=%0d ovf=%b want all zero",
               wr_addr, wr_ptr, wr_full, wr_almost_full, wr_level, wr_overflow);
    end
    tick();
    wr_rst = 1'b1;
    wq2_rptr = '0;
    wr_en = 1'b1;
    #1;
    checks++;
    if (wr_accept !== 1'b1) begin
      errors++; $display("FAIL resume_accept: wr_accept=%b want 1", wr_accept);
    end
    tick();
    wr_en = 1'b0;
    checks++;
    if ({wr_addr, wr_level, wr_ptr} !== {7'd1, 7'd1, 7'h01}) begin
      errors++; $display("FAIL resume: addr=%0d lvl=%0d ptr=%h want addr=1 lvl=1 ptr=01",
                         wr_addr, wr_level, wr_ptr);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_release();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/write_handler.md
Name: write_handler

Overview:
Write-domain pointer and flag logic for the async FIFO. It is the upstream counterpart of the read-side pointer handler and runs entirely on wr_clk. It advances the binary and Gray write pointers on accepted writes, and publishes the Gray write pointer for synchronisation into the read domain. From the twice-synchronised read pointer it derives full, almost-full, fill level and a sticky overflow flag.

Parameters:
- ADDRSIZE, 6, memory address width; DEPTH = 2**ADDRSIZE entries; pointers are ADDRSIZE+1 bits.
- AF_MARGIN, 4, almost-full asserts when free entries <= AF_MARGIN; legal range 1..DEPTH-1.

Ports:
- wr_clk  in  1  write-domain clock.
- wr_rst  in  1  asynchronous, active-low reset.
- wr_en  in  1  write request from producer.
- wq2_rptr  in  ADDRSIZE+1  Gray read pointer, already 2-flop synchronised into wr_clk.
- wr_ovf_clr  in  1  clears sticky overflow.
- wr_accept  out  1  combinational wr_en & !wr_full; memory write enable.
- wr_addr  out  ADDRSIZE+1  registered binary write pointer; memory uses [ADDRSIZE-1:0].
- wr_ptr  out  ADDRSIZE+1  registered Gray write pointer, to read-domain synchroniser.
- wr_full  out  1  registered full flag.
- wr_almost_full  out  1  registered almost-full flag.
- wr_level  out  ADDRSIZE+1  registered fill level, 0..DEPTH.
- wr_overflow  out  1  sticky: a write was attempted while full.

Behaviour:
- Reset (wr_rst low, async): wr_addr=0, wr_ptr=0, wr_full=0, wr_almost_full=0, wr_level=0, wr_overflow=0. Release is synchronous to wr_clk via the existing reset synchroniser.
- wr_binnext = wr_addr + wr_accept, modulo 2**(ADDRSIZE+1); wrap from all-ones to 0 is natural.
- wr_graynext = (wr_binnext >> 1) ^ wr_binnext.
- Each wr_clk edge registers wr_addr<=wr_binnext and wr_ptr<=wr_graynext, so wr_ptr changes at most one bit per cycle.
- Full compare: wr_graynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]}. The result is registered into wr_full.
- The write that fills the last entry asserts wr_full on the same edge that records it, so wr_full is visible in the next cycle.
- rbin = Gray-to-binary of wq2_rptr. level_next = wr_binnext - rbin, modulo 2**(ADDRSIZE+1). This is registered into wr_level.
- wr_almost_full <= (level_next >= DEPTH - AF_MARGIN). It stays asserted while full.
- Flags are pessimistic. Reads become visible 2-3 wr_clk cycles late, so full and level may over-report and never under-report. Full deasserts only after the read pointer moves through the synchroniser.
- wr_en while wr_full: no pointer change and wr_accept=0. wr_overflow is set on the next edge.
- wr_overflow holds until wr_ovf_clr. If set and clear occur in the same cycle, set wins.
- wr_ovf_clr with no pending overflow has no effect.
- A write in the same cycle that wq2_rptr advances out of full is rejected, because wr_full is still 1. It succeeds next cycle.
- Reset mid-operation: all outputs go immediately to reset values. Partially written data is discarded by pointer reset; the read side must be reset together.
- No combinational path from wq2_rptr to any output.

Decomposition:
- Shared package fifo_pkg:
  - ADDRSIZE default and DEPTH derivation.
  - bin2gray and gray2bin functions, reused by the read side.
  - full-compare helper that inverts the two MSBs.
- One sub-module, gray2bin_conv, parameterised by width, for the XOR-prefix conversion of wq2_rptr. Everything else stays flat in write_handler.

Test Plan:
- Reset with wq2_rptr=0, then 64 consecutive wr_en pulses:
  - wr_addr 0..64 (7'h40), wr_ptr=7'h60 at the end.
  - wr_full=1 after the 64th edge.
  - wr_almost_full rises when level reaches 60.
  - wr_level=64.
- While full, hold wr_en for 3 cycles, then pulse wr_ovf_clr:
  - wr_addr stays 64 and wr_accept=0.
  - wr_overflow=1 until the clear edge, then 0.
  - Simultaneous wr_en and wr_ovf_clr leaves it 1.
- From full, step wq2_rptr to Gray(1)=7'h01:
  - wr_full=0 and wr_level=63 one edge later.
  - wr_en is accepted on the following cycle.
- Wrap: preload via traffic so wr_addr=127 with wq2_rptr=Gray(100), then write once:
  - wr_addr=0, wr_ptr=0, wr_level=28, no spurious full.
- Assert wr_rst mid-stream at level 40 with wr_overflow=1:
  - All outputs clear asynchronously before the next wr_clk edge.
  - Writes resume from address 0 after release.
- Check with a bench assertion on every edge: wr_ptr Hamming distance to its previous value is <=1.
